spectag_allocator: RTL and testbench

- Issues one-hot speculative tags to branches at dispatch, up to two per cycle, from a circular pool of NUM_TAGS tags.
- Tracks which tags are outstanding and stalls dispatch when the pool cannot satisfy a request.
- On branch resolution it frees tags, and on a mispredict it computes the kill mask.
- Its outputs drive the setspec ports of the misprediction-fix table and the spectag field of dispatched instructions.

---
 rtl/spectag_allocator_pkg.sv | 35 +++
 rtl/spectag_allocator_chk.sv | 20 ++
 rtl/spectag_kill_gen.sv | 34 +++
 rtl/spectag_allocator.sv | 115 +++++++++++
 tb/tb_spectag_allocator.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/spectag_allocator_pkg.sv
// Shared constants and one-hot helpers for the speculative tag allocator.
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

package spectag_allocator_pkg;

  localparam int NUM_TAGS = `SPECTAG_LEN;
  localparam int DEPTH_W  = $clog2(NUM_TAGS + 1);

  typedef logic [NUM_TAGS-1:0] tag_t;
  typedef logic [DEPTH_W-1:0]  depth_t;

  function automatic tag_t rotl(input tag_t v, input int n);
    logic [2*NUM_TAGS-1:0] d;
    d = {v, v} << n;
    return d[2*NUM_TAGS-1 -: NUM_TAGS];
  endfunction

  function automatic tag_t rotr(input tag_t v, input int n);
    logic [2*NUM_TAGS-1:0] d;
    d = {v, v} >> n;
    return d[NUM_TAGS-1:0];
  endfunction

  function automatic depth_t popcount(input tag_t v);
    depth_t cnt;
    cnt = {DEPTH_W{1'b0}};
    for (int i = 0; i < NUM_TAGS; i++) begin
      cnt = cnt + {{(DEPTH_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/spectag_allocator_chk.sv
// Protocol checks on resolution tags: must be one-hot and currently outstanding.
module spectag_allocator_chk
  import spectag_allocator_pkg::*;
(
  input logic                clk,
  input logic                reset,
  input logic                prsuccess,
  input logic [NUM_TAGS-1:0] prsuccess_tag,
  input logic                prmiss,
  input logic [NUM_TAGS-1:0] prmiss_tag,
  input logic [NUM_TAGS-1:0] busy_mask
);

  a_success_tag: assert property (@(posedge clk) disable iff (reset)
    prsuccess |-> ($onehot(prsuccess_tag) && ((prsuccess_tag & busy_mask) != {NUM_TAGS{1'b0}})));

  a_miss_tag: assert property (@(posedge clk) disable iff (reset)
    prmiss |-> ($onehot(prmiss_tag) && ((prmiss_tag & busy_mask) != {NUM_TAGS{1'b0}})));

endmodule

// File: rtl/spectag_kill_gen.sv
// Kill mask for a mispredict: the branch's own tag plus every busy tag
// younger than it, walking the rotation up to the last-issued slot.
module spectag_kill_gen
  import spectag_allocator_pkg::*;
(
  input  logic [NUM_TAGS-1:0] ptr,
  input  logic [NUM_TAGS-1:0] prmiss_tag,
  input  logic [NUM_TAGS-1:0] busy_mask,
  output logic [NUM_TAGS-1:0] kill_mask
);

  tag_t kill_s;
  tag_t slot_s;
  logic done_s;

  // Walk forward from the mispredicted slot, stopping once ptr is included.
  always_comb begin
    kill_s = prmiss_tag;
    slot_s = prmiss_tag;
    done_s = (ptr == prmiss_tag);
    for (int k = 1; k < NUM_TAGS; k++) begin
      slot_s = rotl(slot_s, 1);
      if (!done_s) begin
        kill_s = kill_s | (slot_s & busy_mask);
        done_s = (slot_s == ptr);
      end else begin
        kill_s = kill_s;
      end
    end
  end

  assign kill_mask = kill_s;

endmodule

// File: rtl/spectag_allocator.sv
// Circular one-hot speculative tag allocator: up to two tags per cycle,
// frees on resolution, squashes younger tags on mispredict.
module spectag_allocator
  import spectag_allocator_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req1,
  input  logic                req2,
  input  logic                prsuccess,
  input  logic [NUM_TAGS-1:0] prsuccess_tag,
  input  logic                prmiss,
  input  logic [NUM_TAGS-1:0] prmiss_tag,
  output logic                grant,
  output logic                stall,
  output logic [NUM_TAGS-1:0] tag1,
  output logic [NUM_TAGS-1:0] tag2,
  output logic                setspec1_en,
  output logic                setspec2_en,
  output logic [NUM_TAGS-1:0] cur_tag,
  output logic [NUM_TAGS-1:0] busy_mask,
  output logic [DEPTH_W-1:0]  depth,
  output logic [NUM_TAGS-1:0] kill_mask
);

  localparam tag_t TAG_RESET = {{(NUM_TAGS-1){1'b0}}, 1'b1};

  tag_t   ptr_r;
  tag_t   busy_r;
  depth_t depth_r;

  tag_t   n1_s, n2_s, need_s, tag2_s, kill_raw_s, kill_s, succ_clr_s, busy_next_s, ptr_next_s;
  logic   grant_s, alloc_s;

  spectag_kill_gen u_kill_gen (
    .ptr        (ptr_r),
    .prmiss_tag (prmiss_tag),
    .busy_mask  (busy_r),
    .kill_mask  (kill_raw_s)
  );

  spectag_allocator_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .prsuccess     (prsuccess),
    .prsuccess_tag (prsuccess_tag),
    .prmiss        (prmiss),
    .prmiss_tag    (prmiss_tag),
    .busy_mask     (busy_r)
  );

  assign n1_s = rotl(ptr_r, 1);
  assign n2_s = rotl(ptr_r, 2);

  // Slots needed by this cycle's request; a lone slot always takes n1.
  always_comb begin
    need_s = {NUM_TAGS{1'b0}};
    tag2_s = n1_s;
    case ({req1, req2})
      2'b00:   need_s = {NUM_TAGS{1'b0}};
      2'b10:   need_s = n1_s;
      2'b01:   need_s = n1_s;
      2'b11: begin
        need_s = n1_s | n2_s;
        tag2_s = n2_s;
      end
      default: need_s = {NUM_TAGS{1'b0}};
    endcase
  end

  // Grant only sees the registered busy mask, so same-cycle frees don't help.
  assign grant_s    = ~prmiss & ((need_s & busy_r) == {NUM_TAGS{1'b0}});
  assign alloc_s    = grant_s & (req1 | req2);
  assign kill_s     = prmiss ? kill_raw_s : {NUM_TAGS{1'b0}};
  assign succ_clr_s = prsuccess ? prsuccess_tag : {NUM_TAGS{1'b0}};

  // Next-state: mispredict rewinds ptr, otherwise a grant advances it.
  always_comb begin
    busy_next_s = busy_r & ~succ_clr_s & ~kill_s;
    ptr_next_s  = ptr_r;
    if (prmiss) begin
      ptr_next_s = rotr(prmiss_tag, 1);
    end else if (alloc_s) begin
      busy_next_s = busy_next_s | need_s;
      ptr_next_s  = (req1 & req2) ? n2_s : n1_s;
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r   <= TAG_RESET;
      busy_r  <= {NUM_TAGS{1'b0}};
      depth_r <= {DEPTH_W{1'b0}};
    end else begin
      ptr_r   <= ptr_next_s;
      busy_r  <= busy_next_s;
      depth_r <= popcount(busy_next_s);
    end
  end

  assign grant       = grant_s;
  assign stall       = (req1 | req2) & ~grant_s;
  assign tag1        = n1_s;
  assign tag2        = tag2_s;
  assign setspec1_en = req1 & grant_s;
  assign setspec2_en = req2 & grant_s;
  assign cur_tag     = ptr_r;
  assign busy_mask   = busy_r;
  assign depth       = depth_r;
  assign kill_mask   = kill_s;

endmodule

// File: tb/tb_spectag_allocator.sv
// Directed self-checking bench for spectag_allocator.
module tb_spectag_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       req1, req2, prsuccess, prmiss;
  logic [4:0] prsuccess_tag, prmiss_tag;
  logic       grant, stall, setspec1_en, setspec2_en;
  logic [4:0] tag1, tag2, cur_tag, busy_mask, kill_mask;
  logic [2:0] depth;

  int tests = 0;
  int fails = 0;

  spectag_allocator dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2),
    .prsuccess(prsuccess), .prsuccess_tag(prsuccess_tag),
    .prmiss(prmiss), .prmiss_tag(prmiss_tag),
    .grant(grant), .stall(stall), .tag1(tag1), .tag2(tag2),
    .setspec1_en(setspec1_en), .setspec2_en(setspec2_en),
    .cur_tag(cur_tag), .busy_mask(busy_mask), .depth(depth), .kill_mask(kill_mask)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r1, input logic r2, input logic ps, input logic [4:0] pst,
                       input logic pm, input logic [4:0] pmt);
    req1 = r1; req2 = r2; prsuccess = ps; prsuccess_tag = pst; prmiss = pm; prmiss_tag = pmt;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (cur_tag !== 5'b00001) begin fails++; $display("FAIL reset_cur_tag: got %b want 00001", cur_tag); end
    tests++; if (busy_mask !== 5'b00000) begin fails++; $display("FAIL reset_busy: got %b want 00000", busy_mask); end
    tests++; if (depth !== 3'd0) begin fails++; $display("FAIL reset_depth: got %0d want 0", depth); end
    tests++; if (stall !== 1'b0 || kill_mask !== 5'b00000) begin fails++; $display("FAIL reset_comb: stall=%b kill=%b want 0/00000", stall, kill_mask); end
    tests++; if (tag1 !== 5'b00010) begin fails++; $display("FAIL reset_tag1: got %b want 00010", tag1); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00010 || grant !== 1'b1) begin fails++; $display("FAIL single_req1: tag1=%b grant=%b want 00010/1", tag1, grant); end
    tests++; if (setspec1_en !== 1'b1 || setspec2_en !== 1'b0) begin fails++; $display("FAIL single_setspec: %b%b want 10", setspec1_en, setspec2_en); end
    step();
    tests++; if (cur_tag !== 5'b00010 || busy_mask !== 5'b00010 || depth !== 3'd1) begin fails++; $display("FAIL single_state: cur=%b busy=%b depth=%0d want 00010/00010/1", cur_tag, busy_mask, depth); end
    drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00100 || tag2 !== 5'b00100 || setspec1_en !== 1'b0 || setspec2_en !== 1'b1) begin fails++; $display("FAIL single_req2: tag1=%b tag2=%b ss=%b%b want 00100/00100/01", tag1, tag2, setspec1_en, setspec2_en); end
    step();
    tests++; if (cur_tag !== 5'b00100 || busy_mask !== 5'b00110 || depth !== 3'd2) begin fails++; $display("FAIL single_req2_state: cur=%b busy=%b depth=%0d want 00100/00110/2", cur_tag, busy_mask, depth); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00010 || tag2 !== 5'b00100 || grant !== 1'b1) begin fails++; $display("FAIL b2b_pair1: tag1=%b tag2=%b grant=%b want 00010/00100/1", tag1, tag2, grant); end
    step();
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b01000 || tag2 !== 5'b10000 || grant !== 1'b1) begin fails++; $display("FAIL b2b_pair2: tag1=%b tag2=%b grant=%b want 01000/10000/1", tag1, tag2, grant); end
    step();
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00001 || grant !== 1'b1) begin fails++; $display("FAIL b2b_third: tag1=%b grant=%b want 00001/1", tag1, grant); end
    step();
    tests++; if (busy_mask !== 5'b11111 || depth !== 3'd5 || cur_tag !== 5'b00001) begin fails++; $display("FAIL b2b_full: busy=%b depth=%0d cur=%b want 11111/5/00001", busy_mask, depth, cur_tag); end
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (stall !== 1'b1 || grant !== 1'b0 || setspec1_en !== 1'b0) begin fails++; $display("FAIL b2b_stall: stall=%b grant=%b ss1=%b want 1/0/0", stall, grant, setspec1_en); end
    step();
    tests++; if (busy_mask !== 5'b11111 || cur_tag !== 5'b00001) begin fails++; $display("FAIL b2b_hold: busy=%b cur=%b want 11111/00001", busy_mask, cur_tag); end
  endtask

  // Continues from the full pool left by test_back_to_back.
  task automatic test_full_free();
    drive(1'b1, 1'b0, 1'b1, 5'b00010, 1'b0, 5'b00000);
    tests++; if (stall !== 1'b1 || grant !== 1'b0) begin fails++; $display("FAIL free_same_cycle: stall=%b grant=%b want 1/0", stall, grant); end
    step();
    tests++; if (busy_mask !== 5'b11101 || depth !== 3'd4) begin fails++; $display("FAIL free_state: busy=%b depth=%0d want 11101/4", busy_mask, depth); end
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00010 || grant !== 1'b1) begin fails++; $display("FAIL free_regrant: tag1=%b grant=%b want 00010/1", tag1, grant); end
    step();
    tests++; if (busy_mask !== 5'b11111 || cur_tag !== 5'b00010 || depth !== 3'd5) begin fails++; $display("FAIL free_refill: busy=%b cur=%b depth=%0d want 11111/00010/5", busy_mask, cur_tag, depth); end
  endtask

  task automatic test_prmiss();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
      step();
    end
    tests++; if (busy_mask !== 5'b01110 || cur_tag !== 5'b01000) begin fails++; $display("FAIL miss_setup: busy=%b cur=%b want 01110/01000", busy_mask, cur_tag); end
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00100);
    tests++; if (kill_mask !== 5'b01100 || grant !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL miss_kill: kill=%b grant=%b stall=%b want 01100/0/1", kill_mask, grant, stall); end
    step();
    tests++; if (busy_mask !== 5'b00010 || cur_tag !== 5'b00010 || depth !== 3'd1) begin fails++; $display("FAIL miss_state: busy=%b cur=%b depth=%0d want 00010/00010/1", busy_mask, cur_tag, depth); end
    tests++; if (kill_mask !== 5'b00000) begin fails++; $display("FAIL miss_kill_idle: got %b want 00000", kill_mask); end
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00100 || grant !== 1'b1) begin fails++; $display("FAIL miss_reissue: tag1=%b grant=%b want 00100/1", tag1, grant); end
    step();
    tests++; if (busy_mask !== 5'b00110 || cur_tag !== 5'b00100) begin fails++; $display("FAIL miss_reissue_state: busy=%b cur=%b want 00110/00100", busy_mask, cur_tag); end
  endtask

  task automatic test_wrap_kill();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000); step();
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000); step();
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000); step();
    drive(1'b0, 1'b0, 1'b1, 5'b00010, 1'b0, 5'b00000); step();
    drive(1'b0, 1'b0, 1'b1, 5'b00100, 1'b0, 5'b00000); step();
    tests++; if (busy_mask !== 5'b11001 || cur_tag !== 5'b00001 || depth !== 3'd3) begin fails++; $display("FAIL wrap_setup: busy=%b cur=%b depth=%0d want 11001/00001/3", busy_mask, cur_tag, depth); end
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b01000);
    tests++; if (kill_mask !== 5'b11001) begin fails++; $display("FAIL wrap_kill: got %b want 11001", kill_mask); end
    step();
    tests++; if (busy_mask !== 5'b00000 || cur_tag !== 5'b00100 || depth !== 3'd0) begin fails++; $display("FAIL wrap_kill_state: busy=%b cur=%b depth=%0d want 00000/00100/0", busy_mask, cur_tag, depth); end
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000); step();
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000);
    tests++; if (tag1 !== 5'b00001 || tag2 !== 5'b00010 || grant !== 1'b1) begin fails++; $display("FAIL wrap_pair: tag1=%b tag2=%b grant=%b want 00001/00010/1", tag1, tag2, grant); end
    step();
    tests++; if (busy_mask !== 5'b11011 || cur_tag !== 5'b00010 || depth !== 3'd4) begin fails++; $display("FAIL wrap_pair_state: busy=%b cur=%b depth=%0d want 11011/00010/4", busy_mask, cur_tag, depth); end
  endtask

  task automatic test_simul_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000); step();
    drive(1'b0, 1'b0, 1'b1, 5'b00010, 1'b1, 5'b00100);
    tests++; if (kill_mask !== 5'b00100) begin fails++; $display("FAIL simul_kill: got %b want 00100", kill_mask); end
    step();
    tests++; if (busy_mask !== 5'b00000 || depth !== 3'd0 || cur_tag !== 5'b00010) begin fails++; $display("FAIL simul_state: busy=%b depth=%0d cur=%b want 00000/0/00010", busy_mask, depth, cur_tag); end
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000); step();
    tests++; if (busy_mask !== 5'b00100 || cur_tag !== 5'b00100) begin fails++; $display("FAIL simul_realloc: busy=%b cur=%b want 00100/00100", busy_mask, cur_tag); end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000);
    @(posedge clk); #1;
    tests++; if (cur_tag !== 5'b00001 || busy_mask !== 5'b00000 || depth !== 3'd0) begin fails++; $display("FAIL midreset: cur=%b busy=%b depth=%0d want 00001/00000/0", cur_tag, busy_mask, depth); end
    reset = 1'b0;
    #1;
    tests++; if (tag1 !== 5'b00010 || grant !== 1'b1) begin fails++; $display("FAIL post_reset_grant: tag1=%b grant=%b want 00010/1", tag1, grant); end
    step();
    tests++; if (busy_mask !== 5'b00010 || cur_tag !== 5'b00010 || depth !== 3'd1) begin fails++; $display("FAIL post_reset_state: busy=%b cur=%b depth=%0d want 00010/00010/1", busy_mask, cur_tag, depth); end
  endtask

  initial begin
    reset = 1'b1;
    req1 = 1'b0; req2 = 1'b0; prsuccess = 1'b0; prmiss = 1'b0;
    prsuccess_tag = 5'b00000; prmiss_tag = 5'b00000;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_free();
    test_prmiss();
    test_wrap_kill();
    test_simul_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
